// File: rtl/i2c_master_lite_if.sv
// i2c_master_lite_if: host request/response and I2C pin bundle for i2c_master_lite.
//   master modport (the I2C master block):
//     in : start, rw, addr, wdata, scl_in, sda_in
//     out: rdata, busy, done, ack_err, scl_drive_low, sda_drive_low
//   slave modport (host logic / pad side): the same signals with directions reversed.
interface i2c_master_lite_if #(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned DATA_BITS = 6
) ();
    logic                 start;
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] rdata;
    logic                 busy;
    logic                 done;
    logic                 ack_err;
    logic                 scl_in;
    logic                 scl_drive_low;
    logic                 sda_in;
    logic                 sda_drive_low;

    modport master (
        input  start, rw, addr, wdata, scl_in, sda_in,
        output rdata, busy, done, ack_err, scl_drive_low, sda_drive_low
    );

    modport slave (
        output start, rw, addr, wdata, scl_in, sda_in,
        input  rdata, busy, done, ack_err, scl_drive_low, sda_drive_low
    );
endinterface

// File: rtl/i2c_master_lite.sv
// i2c_master_lite: single-frame I2C master for a small on-chip minion.
// Frame: START, ADDR_BITS address bits, R/W, address ACK, DATA_BITS data bits, data ACK, STOP.
// An address NACK skips the data phase and goes straight to STOP.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset; releases both bus lines at once, no STOP
//   bus   - i2c_master_lite_if.master: start/rw/addr/wdata request, rdata/busy/done/ack_err
//           status, scl_in/sda_in sensed pins, scl_drive_low/sda_drive_low open-drain pulls
// Optional feature: define I2C_MASTER_CLOCK_STRETCH_EN to freeze bit timing while the master
// releases SCL but the line is still held low by the target. Without it scl_in is ignored.
module i2c_master_lite #(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned DATA_BITS = 6,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    i2c_master_lite_if.master        bus
);

    localparam int unsigned MaxBits = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
    localparam int unsigned BitW    = (MaxBits > 1) ? $clog2(MaxBits) : 1;
    localparam logic [7:0]      QMax     = 8'(CLK_DIV - 1);
    localparam logic [BitW-1:0] AddrLast = BitW'(ADDR_BITS - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StRw,
        StAack,
        StData,
        StDack,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           qcnt_q, qcnt_d;
    logic [1:0]           phase_q, phase_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 rw_q, rw_d;
    logic [ADDR_BITS-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_BITS-1:0] data_sh_q, data_sh_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 ack_err_q, ack_err_d;
    logic                 done_q, done_d;

    logic stall;
    logic tick;
    logic sample;
    logic slot_end;
    logic scl_low;
    logic sda_low;

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
    // Target holds SCL low after we released it: hold the bit timing until it lets go.
    assign stall = phase_q[1] && !bus.scl_in && (state_q != StIdle);
`else
    assign stall = 1'b0;
    logic unused_scl_in;
    assign unused_scl_in = bus.scl_in;
`endif

    assign tick     = (qcnt_q == QMax) && !stall;
    // SDA is sampled on the last clk of q2, while SCL is high.
    assign sample   = tick && (phase_q == 2'd2);
    assign slot_end = tick && (phase_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            qcnt_q    <= '0;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            rw_q      <= 1'b0;
            addr_sh_q <= '0;
            data_sh_q <= '0;
            rx_sh_q   <= '0;
            rdata_q   <= '0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            rw_q      <= rw_d;
            addr_sh_q <= addr_sh_d;
            data_sh_q <= data_sh_d;
            rx_sh_q   <= rx_sh_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        rw_d      = rw_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        rx_sh_d   = rx_sh_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        if (state_q != StIdle && !stall) begin
            if (qcnt_q == QMax) begin
                qcnt_d  = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q + 8'd1;
            end
        end

        case (state_q)
            StIdle: begin
                qcnt_d  = '0;
                phase_d = '0;
                // A start coinciding with the done pulse belongs to the finished frame.
                if (bus.start && !done_q) begin
                    state_d   = StStart;
                    rw_d      = bus.rw;
                    addr_sh_d = bus.addr;
                    data_sh_d = bus.wdata;
                    rx_sh_d   = '0;
                    ack_err_d = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            StStart: begin
                if (slot_end) begin
                    state_d   = StAddr;
                    bit_cnt_d = '0;
                end
            end
            StAddr: begin
                if (slot_end) begin
                    addr_sh_d = addr_sh_q << 1;
                    if (bit_cnt_q == AddrLast) begin
                        state_d   = StRw;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StRw: begin
                if (slot_end) begin
                    state_d = StAack;
                end
            end
            StAack: begin
                if (sample && bus.sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (slot_end) begin
                    state_d   = ack_err_q ? StStop : StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (sample && rw_q) begin
                    rx_sh_d = {rx_sh_q[DATA_BITS-2:0], bus.sda_in};
                end
                if (slot_end) begin
                    data_sh_d = data_sh_q << 1;
                    if (bit_cnt_q == DataLast) begin
                        state_d   = StDack;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StDack: begin
                // On a read the master NACKs the single byte, so nothing to check.
                if (sample && !rw_q && bus.sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (slot_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (slot_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (rw_q && !ack_err_q) begin
                        rdata_d = rx_sh_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pin drive decode; SDA changes at q0 entry together with the SCL fall.
    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (state_q)
            StIdle: begin
                scl_low = 1'b0;
                sda_low = 1'b0;
            end
            StStart: begin
                sda_low = phase_q[1];
            end
            StAddr: begin
                scl_low = !phase_q[1];
                sda_low = !addr_sh_q[ADDR_BITS-1];
            end
            StRw: begin
                scl_low = !phase_q[1];
                sda_low = !rw_q;
            end
            StAack, StDack: begin
                scl_low = !phase_q[1];
            end
            StData: begin
                scl_low = !phase_q[1];
                sda_low = !rw_q && !data_sh_q[DATA_BITS-1];
            end
            StStop: begin
                scl_low = (phase_q == 2'd0);
                sda_low = (phase_q != 2'd3);
            end
            default: begin
                scl_low = 1'b0;
                sda_low = 1'b0;
            end
        endcase
    end

    assign bus.scl_drive_low = scl_low;
    assign bus.sda_drive_low = sda_low;
    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = done_q;
    assign bus.ack_err       = ack_err_q;
    assign bus.rdata         = rdata_q;

endmodule

// File: tb/tb_i2c_master_lite.sv
// Directed bench for i2c_master_lite (CLK_DIV=4) with a behavioural bus minion.
module tb_i2c_master_lite;

    logic clk;
    logic rst_n;
    logic scl_hold;
    logic minion_low;

    int total;
    int bad;

    // Minion configuration per scenario.
    logic       m_ack;
    logic       m_read;
    logic [5:0] m_data;

    // Bus monitor state.
    logic [13:0] cap;
    int          rises;
    int          falls;
    int          start_cnt;
    int          stop_cnt;
    logic        prev_scl;
    logic        prev_sda;

    i2c_master_lite_if #(.ADDR_BITS(4), .DATA_BITS(6)) bus ();

    i2c_master_lite #(
        .ADDR_BITS(4),
        .DATA_BITS(6),
        .CLK_DIV  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Wired-AND open-drain lines.
    assign bus.scl_in = !bus.scl_drive_low && !scl_hold;
    assign bus.sda_in = !bus.sda_drive_low && !minion_low;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minion: records SDA at SCL rises, drives ACK/read data after SCL falls.
    always @(negedge clk) begin
        logic scl_now;
        logic sda_now;
        scl_now = !bus.scl_drive_low && !scl_hold;
        sda_now = !bus.sda_drive_low && !minion_low;
        if (prev_scl && scl_now && prev_sda && !sda_now) begin
            start_cnt++;
            rises = 0;
            falls = 0;
            cap   = '0;
        end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
            stop_cnt++;
        end
        if (!prev_scl && scl_now) begin
            cap = {cap[12:0], sda_now};
            rises++;
        end
        if (prev_scl && !scl_now) begin
            if (falls == 5) minion_low = m_ack;
            else if (falls >= 6 && falls <= 11) minion_low = m_ack && m_read && !m_data[11-falls];
            else if (falls == 12) minion_low = m_ack && !m_read;
            else minion_low = 1'b0;
            falls++;
        end
        prev_scl = scl_now;
        prev_sda = sda_now;
    end

    // Issues one request and watches done for max_cyc clocks after the accept edge.
    task automatic do_frame(input logic r, input logic [3:0] a, input logic [5:0] d,
                            input int inject_at, input int hold_at, input int max_cyc,
                            output int lat, output int nd, output logic acc_busy,
                            output logic acc_err);
        @(negedge clk);
        bus.start = 1'b1;
        bus.rw    = r;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        acc_busy  = bus.busy;
        acc_err   = bus.ack_err;
        lat = -1;
        nd  = 0;
        for (int n = 1; n <= max_cyc; n++) begin
            if (inject_at != 0 && n - 1 == inject_at) begin
                bus.start = 1'b1;
                bus.addr  = 4'b1111;
                bus.wdata = 6'b000000;
            end else begin
                bus.start = 1'b0;
            end
            if (hold_at != 0 && n - 1 == hold_at) scl_hold = 1'b1;
            if (hold_at != 0 && n - 1 == hold_at + 20) scl_hold = 1'b0;
            @(posedge clk);
            #1;
            if (bus.done) begin
                nd++;
                if (lat < 0) lat = n;
            end
        end
        bus.start = 1'b0;
        scl_hold  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ack_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: busy=%b done=%b ack_err=%b want 0 0 0",
                     bus.busy, bus.done, bus.ack_err);
        end
        total++;
        if (bus.rdata !== 6'b000000) begin
            bad++;
            $display("FAIL reset_rdata: got %b want 000000", bus.rdata);
        end
        total++;
        if (bus.scl_drive_low !== 1'b0 || bus.sda_drive_low !== 1'b0) begin
            bad++;
            $display("FAIL reset_lines: scl_low=%b sda_low=%b want 0 0",
                     bus.scl_drive_low, bus.sda_drive_low);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write();
        int lat, nd, stops;
        logic ab, ae;
        m_ack = 1'b1; m_read = 1'b0; m_data = '0;
        stops = stop_cnt;
        do_frame(1'b0, 4'b0010, 6'b101101, 0, 0, 260, lat, nd, ab, ae);
        total++;
        if (ab !== 1'b1) begin bad++; $display("FAIL write_busy_on_accept: got %b want 1", ab); end
        total++;
        if (lat != 240) begin bad++; $display("FAIL write_latency: got %0d want 240", lat); end
        total++;
        if (nd != 1) begin bad++; $display("FAIL write_done_count: got %0d want 1", nd); end
        total++;
        if (cap !== 14'b0010_0_0_101101_0_0 || rises != 14) begin
            bad++;
            $display("FAIL write_bus_bits: got %b (%0d rises) want 00100010110100 (14)", cap, rises);
        end
        total++;
        if (bus.ack_err !== 1'b0 || bus.rdata !== 6'b000000 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL write_status: ack_err=%b rdata=%b busy=%b want 0 000000 0",
                     bus.ack_err, bus.rdata, bus.busy);
        end
        total++;
        if (stop_cnt != stops + 1) begin
            bad++;
            $display("FAIL write_stop: got %0d stops want %0d", stop_cnt - stops, 1);
        end
    endtask

    task automatic test_read();
        int lat, nd;
        logic ab, ae;
        m_ack = 1'b1; m_read = 1'b1; m_data = 6'b011010;
        do_frame(1'b1, 4'b0010, 6'b000000, 0, 0, 260, lat, nd, ab, ae);
        total++;
        if (lat != 240 || nd != 1) begin
            bad++;
            $display("FAIL read_latency: got %0d (%0d dones) want 240 (1)", lat, nd);
        end
        total++;
        if (bus.rdata !== 6'b011010) begin
            bad++;
            $display("FAIL read_rdata: got %b want 011010", bus.rdata);
        end
        total++;
        if (cap !== 14'b0010_1_0_011010_1_0 || rises != 14) begin
            bad++;
            $display("FAIL read_bus_bits: got %b (%0d rises) want 00101001101010 (14)", cap, rises);
        end
        total++;
        if (bus.ack_err !== 1'b0) begin
            bad++;
            $display("FAIL read_ack_err: got %b want 0", bus.ack_err);
        end
    endtask

    task automatic test_addr_nack();
        int lat, nd, stops;
        logic ab, ae;
        m_ack = 1'b0; m_read = 1'b1; m_data = 6'b111111;
        stops = stop_cnt;
        do_frame(1'b1, 4'b0111, 6'b000000, 0, 0, 150, lat, nd, ab, ae);
        total++;
        if (lat != 128 || nd != 1) begin
            bad++;
            $display("FAIL nack_latency: got %0d (%0d dones) want 128 (1)", lat, nd);
        end
        total++;
        if (bus.ack_err !== 1'b1) begin
            bad++;
            $display("FAIL nack_ack_err: got %b want 1", bus.ack_err);
        end
        total++;
        if (bus.rdata !== 6'b011010) begin
            bad++;
            $display("FAIL nack_rdata_kept: got %b want 011010", bus.rdata);
        end
        total++;
        if (cap !== 14'b0000000_0111110 || rises != 7 || stop_cnt != stops + 1) begin
            bad++;
            $display("FAIL nack_bus_bits: got %b (%0d rises, %0d stops) want 0111110 (7, 1)",
                     cap, rises, stop_cnt - stops);
        end
    endtask

    task automatic test_busy_start();
        int lat, nd;
        logic ab, ae;
        m_ack = 1'b1; m_read = 1'b0; m_data = '0;
        do_frame(1'b0, 4'b0010, 6'b110011, 50, 0, 300, lat, nd, ab, ae);
        total++;
        if (ae !== 1'b0) begin
            bad++;
            $display("FAIL busy_ack_err_cleared: got %b want 0", ae);
        end
        total++;
        if (lat != 240 || nd != 1) begin
            bad++;
            $display("FAIL busy_start_ignored: got %0d (%0d dones) want 240 (1)", lat, nd);
        end
        total++;
        if (cap !== 14'b0010_0_0_110011_0_0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_bus_bits: got %b busy=%b want 00100011001100 busy=0", cap, bus.busy);
        end
    endtask

    task automatic test_done_start();
        int lat, nd;
        logic ab, ae;
        m_ack = 1'b1; m_read = 1'b0; m_data = '0;
        do_frame(1'b0, 4'b0010, 6'b000111, 0, 0, 240, lat, nd, ab, ae);
        total++;
        if (lat != 240 || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL done_edge: got lat=%0d done=%b want 240 1", lat, bus.done);
        end
        bus.start = 1'b1;
        bus.rw    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL start_with_done_ignored: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        m_read = 1'b1; m_data = 6'b100101;
        do_frame(1'b1, 4'b0010, 6'b000000, 0, 0, 250, lat, nd, ab, ae);
        total++;
        if (lat != 240 || bus.rdata !== 6'b100101) begin
            bad++;
            $display("FAIL after_done_read: got lat=%0d rdata=%b want 240 100101", lat, bus.rdata);
        end
    endtask

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
    task automatic test_stretch();
        int lat, nd;
        logic ab, ae;
        m_ack = 1'b1; m_read = 1'b0; m_data = '0;
        do_frame(1'b0, 4'b0010, 6'b101101, 0, 104, 290, lat, nd, ab, ae);
        total++;
        if (lat != 260 || nd != 1) begin
            bad++;
            $display("FAIL stretch_latency: got %0d (%0d dones) want 260 (1)", lat, nd);
        end
        total++;
        if (cap !== 14'b0010_0_0_101101_0_0 || bus.ack_err !== 1'b0) begin
            bad++;
            $display("FAIL stretch_bus_bits: got %b ack_err=%b want 00100010110100 0",
                     cap, bus.ack_err);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int lat, nd;
        logic ab, ae;
        m_ack = 1'b1; m_read = 1'b0; m_data = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.rw    = 1'b0;
        bus.addr  = 4'b0010;
        bus.wdata = 6'b101101;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        minion_low = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.scl_drive_low !== 1'b0 || bus.sda_drive_low !== 1'b0) begin
            bad++;
            $display("FAIL midreset_release: busy=%b scl_low=%b sda_low=%b want 0 0 0",
                     bus.busy, bus.scl_drive_low, bus.sda_drive_low);
        end
        total++;
        if (bus.rdata !== 6'b000000) begin
            bad++;
            $display("FAIL midreset_rdata: got %b want 000000", bus.rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        do_frame(1'b0, 4'b0010, 6'b101101, 0, 0, 260, lat, nd, ab, ae);
        total++;
        if (lat != 240 || nd != 1 || cap !== 14'b0010_0_0_101101_0_0 || bus.ack_err !== 1'b0) begin
            bad++;
            $display("FAIL midreset_recover: lat=%0d dones=%0d bits=%b ack_err=%b want 240 1 00100010110100 0",
                     lat, nd, cap, bus.ack_err);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rises      = 0;
        falls      = 0;
        start_cnt  = 0;
        stop_cnt   = 0;
        cap        = '0;
        prev_scl   = 1'b1;
        prev_sda   = 1'b1;
        scl_hold   = 1'b0;
        minion_low = 1'b0;
        m_ack      = 1'b0;
        m_read     = 1'b0;
        m_data     = '0;
        bus.start  = 1'b0;
        bus.rw     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        rst_n      = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_busy_start();
        test_done_start();
`ifdef I2C_MASTER_CLOCK_STRETCH_EN
        test_stretch();
`endif
        test_reset_mid_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
